// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a big-endian byte stream into
// 32-bit words and writes them to ascending addresses from 0.
module imem_loader #(
  parameter int INSTRUCT_MEM_SIZE = 1024,
  parameter int CW = $clog2(INSTRUCT_MEM_SIZE / 4) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    in_byte,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          finish,
  output logic          wr_en,
  output logic [63:0]   wr_addr,
  output logic [31:0]   wr_data,
  output logic [CW-1:0] word_count,
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);

  localparam logic [CW-1:0] CAP = CW'(INSTRUCT_MEM_SIZE / 4);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t        state, state_n;
  logic [1:0]    byte_idx, idx_n;
  logic [23:0]   word_buf, buf_n;
  logic [CW-1:0] count_n;
  logic [63:0]   addr_n;
  logic [31:0]   data_n;
  logic          finish_pend, pend_n;
  logic          xfer;
  logic [31:0]   word;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      byte_idx    <= '0;
      word_buf    <= '0;
      word_count  <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      finish_pend <= 1'b0;
    end else begin
      state       <= state_n;
      byte_idx    <= idx_n;
      word_buf    <= buf_n;
      word_count  <= count_n;
      wr_addr     <= addr_n;
      wr_data     <= data_n;
      finish_pend <= pend_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = byte_idx;
    buf_n   = word_buf;
    count_n = word_count;
    addr_n  = wr_addr;
    data_n  = wr_data;
    pend_n  = finish_pend;
    xfer    = in_valid && (state == LOAD);
    word    = {word_buf, in_byte};
    if (start) begin
      state_n = LOAD;
      count_n = '0;
      idx_n   = '0;
      pend_n  = 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          // a byte arriving with the RAM already full is an overflow
          if (xfer && word_count == CAP) begin
            state_n = ERROR;
          end else begin
            if (xfer) begin
              buf_n = word[23:0];
              idx_n = byte_idx + 2'd1;
            end
            if (xfer && byte_idx == 2'd3) begin
              state_n = WRITE;
              pend_n  = finish;
              addr_n  = 64'(word_count) << 2;
              data_n  = word;
            end else if (finish) begin
              state_n = (idx_n == 2'd0) ? DONE : ERROR;
            end
          end
        end
        WRITE: begin
          count_n = word_count + 1'b1;
          pend_n  = 1'b0;
          state_n = (finish_pend || finish) ? DONE : LOAD;
        end
        default: ;
      endcase
    end
  end

  assign in_ready = (state == LOAD);
  assign wr_en    = (state == WRITE);
  assign done     = (state == DONE);
  assign error    = (state == ERROR);
  assign cpu_hold = (state != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a 1 KiB instance and a 16-byte
// instance share the stimulus; expected writes are queued per instance.
module tb_imem_loader;

  typedef struct packed {
    logic [63:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 0;
  logic        reset = 0;
  logic        start = 0;
  logic [7:0]  in_byte = 0;
  logic        in_valid = 0;
  logic        finish = 0;

  logic        in_ready, wr_en, cpu_hold, done, error;
  logic [63:0] wr_addr;
  logic [31:0] wr_data;
  logic [8:0]  word_count;

  logic        rdy16, wen16, hold16, done16, err16;
  logic [63:0] addr16;
  logic [31:0] data16;
  logic [2:0]  wc16;

  int vectors = 0;
  int errs = 0;
  wr_t q[$];
  wr_t q16[$];

  always #5 clk = ~clk;

  imem_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .finish(finish), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .word_count(word_count),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  imem_loader #(.INSTRUCT_MEM_SIZE(16)) dut16 (
    .clk(clk), .reset(reset), .start(start),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(rdy16),
    .finish(finish), .wr_en(wen16), .wr_addr(addr16),
    .wr_data(data16), .word_count(wc16),
    .cpu_hold(hold16), .done(done16), .error(err16)
  );

  always @(negedge clk) begin
    wr_t e;
    if (wr_en) begin
      vectors++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL wr big: unexpected @%h %h", wr_addr, wr_data);
      end else begin
        e = q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          errs++;
          $display("FAIL wr big: got @%h %h exp @%h %h",
                   wr_addr, wr_data, e.a, e.d);
        end
      end
    end
    if (wen16) begin
      vectors++;
      if (q16.size() == 0) begin
        errs++;
        $display("FAIL wr small: unexpected @%h %h", addr16, data16);
      end else begin
        e = q16.pop_front();
        if ({addr16, data16} !== e) begin
          errs++;
          $display("FAIL wr small: got @%h %h exp @%h %h",
                   addr16, data16, e.a, e.d);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 0;
    step();
    step();
    reset = 1;
  endtask

  task automatic start_pulse();
    start = 1;
    step();
    start = 0;
  endtask

  task automatic finish_pulse();
    finish = 1;
    step();
    finish = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    logic r;
    n = 0;
    r = 0;
    in_valid = 1;
    in_byte = b;
    while (!r && n < 20) begin
      @(negedge clk);
      r = in_ready;
      step();
      n++;
    end
    in_valid = 0;
    if (!r) begin
      vectors++;
      errs++;
      $display("FAIL send_byte: in_ready=0 for 20 cycles, exp 1");
    end
  endtask

  task automatic push(input logic [63:0] a, input logic [31:0] d);
    q.push_back('{a: a, d: d});
    q16.push_back('{a: a, d: d});
  endtask

  task automatic send_word(input logic [31:0] w, input logic [63:0] a,
                           input int maxgap);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) push(a, w);
      send_byte(w[31-8*i -: 8]);
      repeat ($urandom_range(0, maxgap)) step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++;
    if ({in_ready, wr_en, wr_addr, wr_data, word_count,
         cpu_hold, done, error} !== {2'b0, 64'h0, 32'h0, 9'h0, 3'b100}) begin
      errs++;
      $display("FAIL reset: rdy=%b wen=%b a=%h d=%h wc=%0d hold=%b dn=%b er=%b",
               in_ready, wr_en, wr_addr, wr_data, word_count,
               cpu_hold, done, error);
    end
    step();
  endtask

  task automatic test_program();
    do_reset();
    start_pulse();
    send_word(32'hF80003E0, 64'd0, 0);
    send_word(32'h91000421, 64'd4, 0);
    finish_pulse();
    @(negedge clk);
    vectors++;
    if ({word_count, done, cpu_hold, error} !== {9'd2, 3'b100}) begin
      errs++;
      $display("FAIL program: wc=%0d dn=%b hold=%b er=%b exp 2 1 0 0",
               word_count, done, cpu_hold, error);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [8];
    logic [9:0] pat;
    logic r;
    int idx;
    bytes = '{8'h13, 8'h57, 8'h9B, 8'hDF, 8'h02, 8'h46, 8'h8A, 8'hCE};
    pat = 10'b0111101111;
    do_reset();
    start_pulse();
    push(64'd0, 32'h13579BDF);
    push(64'd4, 32'h02468ACE);
    idx = 0;
    in_valid = 1;
    for (int c = 0; c < 10; c++) begin
      in_byte = (idx < 8) ? bytes[idx] : 8'h00;
      in_valid = (idx < 8);
      @(negedge clk);
      r = in_ready;
      vectors++;
      if (r !== pat[c]) begin
        errs++;
        $display("FAIL b2b ready c%0d: got %b exp %b", c, r, pat[c]);
      end
      step();
      if (r && idx < 8) idx++;
    end
    in_valid = 0;
    finish_pulse();
    do_reset();
    start_pulse();
    send_word(32'h13579BDF, 64'd0, 3);
    send_word(32'h02468ACE, 64'd4, 3);
    finish_pulse();
    @(negedge clk);
    vectors++;
    if ({word_count, done} !== {9'd2, 1'b1}) begin
      errs++;
      $display("FAIL gaps: wc=%0d dn=%b exp 2 1", word_count, done);
    end
    step();
  endtask

  task automatic test_partial();
    do_reset();
    start_pulse();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    finish_pulse();
    @(negedge clk);
    vectors++;
    if ({error, done, cpu_hold, word_count} !== {3'b101, 9'd0}) begin
      errs++;
      $display("FAIL partial: er=%b dn=%b hold=%b wc=%0d exp 1 0 1 0",
               error, done, cpu_hold, word_count);
    end
    step();
  endtask

  task automatic test_overflow();
    do_reset();
    start_pulse();
    for (int i = 0; i < 4; i++)
      send_word(32'hA0B0C0D0 + i, 64'(4 * i), 0);
    step();
    send_byte(8'h55);
    @(negedge clk);
    vectors++;
    if ({err16, done16, hold16, wc16} !== {3'b101, 3'd4}) begin
      errs++;
      $display("FAIL overflow: er=%b dn=%b hold=%b wc=%0d exp 1 0 1 4",
               err16, done16, hold16, wc16);
    end
    repeat (4) step();
    vectors++;
    if (err16 !== 1'b1) begin
      errs++;
      $display("FAIL overflow hold: er=%b exp 1", err16);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_pulse();
    send_word(32'h0BADF00D, 64'd0, 0);
    send_byte(8'h77);
    send_byte(8'h88);
    reset = 0;
    step();
    @(negedge clk);
    vectors++;
    if ({in_ready, wr_en, wr_addr, wr_data, word_count,
         cpu_hold, done, error} !== {2'b0, 64'h0, 32'h0, 9'h0, 3'b100}) begin
      errs++;
      $display("FAIL reset mid: rdy=%b wen=%b a=%h d=%h wc=%0d hold=%b dn=%b er=%b",
               in_ready, wr_en, wr_addr, wr_data, word_count,
               cpu_hold, done, error);
    end
    step();
    reset = 1;
    start_pulse();
    send_word(32'hAABBCCDD, 64'd0, 0);
    finish_pulse();
    @(negedge clk);
    vectors++;
    if ({word_count, done} !== {9'd1, 1'b1}) begin
      errs++;
      $display("FAIL reset mid reload: wc=%0d dn=%b exp 1 1",
               word_count, done);
    end
    step();
  endtask

  task automatic test_finish_same();
    do_reset();
    start_pulse();
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    push(64'd0, 32'h12345678);
    finish = 1;
    send_byte(8'h78);
    finish = 0;
    @(negedge clk);
    vectors++;
    if ({wr_en, done} !== 2'b10) begin
      errs++;
      $display("FAIL fin same wr: wen=%b dn=%b exp 1 0", wr_en, done);
    end
    step();
    @(negedge clk);
    vectors++;
    if ({done, cpu_hold, word_count} !== {2'b10, 9'd1}) begin
      errs++;
      $display("FAIL fin same done: dn=%b hold=%b wc=%0d exp 1 0 1",
               done, cpu_hold, word_count);
    end
    step();
    start_pulse();
    @(negedge clk);
    vectors++;
    if ({done, cpu_hold, word_count, in_ready} !== {2'b01, 9'd0, 1'b1}) begin
      errs++;
      $display("FAIL restart: dn=%b hold=%b wc=%0d rdy=%b exp 0 1 0 1",
               done, cpu_hold, word_count, in_ready);
    end
    step();
  endtask

  initial begin
    #1;
    test_reset();
    test_program();
    test_back_to_back();
    test_partial();
    test_overflow();
    test_reset_mid();
    test_finish_same();
    repeat (3) step();
    vectors++;
    if (q.size() != 0 || q16.size() != 0) begin
      errs++;
      $display("FAIL missing writes: big=%0d small=%0d exp 0 0",
               q.size(), q16.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
